// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR constants, default maximal tap masks and next-state function
package lfsr_pkg;

    localparam int unsigned LFSR_MIN_W = 2;
    localparam int unsigned LFSR_MAX_W = 8;

    localparam logic [3:0] LFSR_DEFAULT_SEED = 4'b0001;

    // Maximal-length Fibonacci tap masks; bit i set means state[i] feeds the XOR.
    localparam logic [1:0] LFSR_TAPS_W2 = 2'b11;
    localparam logic [2:0] LFSR_TAPS_W3 = 3'b110;
    localparam logic [3:0] LFSR_TAPS_W4 = 4'b1100;
    localparam logic [4:0] LFSR_TAPS_W5 = 5'b10100;
    localparam logic [5:0] LFSR_TAPS_W6 = 6'b110000;
    localparam logic [6:0] LFSR_TAPS_W7 = 7'b1100000;
    localparam logic [7:0] LFSR_TAPS_W8 = 8'b10111000;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_default_taps(input int unsigned width);
        logic [LFSR_MAX_W-1:0] taps;
        taps = '0;
        case (width)
            2:       taps = {6'b0, LFSR_TAPS_W2};
            3:       taps = {5'b0, LFSR_TAPS_W3};
            4:       taps = {4'b0, LFSR_TAPS_W4};
            5:       taps = {3'b0, LFSR_TAPS_W5};
            6:       taps = {2'b0, LFSR_TAPS_W6};
            7:       taps = {1'b0, LFSR_TAPS_W7};
            8:       taps = LFSR_TAPS_W8;
            default: taps = '0;
        endcase
        return taps;
    endfunction

    // Next state for a register of 'width' bits held right-aligned in an LFSR_MAX_W vector.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width
    );
        logic                  fb;
        logic [LFSR_MAX_W:0]   mask_ext;
        logic [LFSR_MAX_W-1:0] shifted;
        fb       = ^(state & taps);
        mask_ext = (9'd1 << width) - 9'd1;
        shifted  = {state[LFSR_MAX_W-2:0], fb};
        return shifted & mask_ext[LFSR_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// rtl/lfsr_rng_if.sv - random value stream from the LFSR to the game datapath
interface lfsr_rng_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] value;

    modport master (output value);
    modport slave  (input  value);
endinterface

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - free-running Fibonacci LFSR; optional LFSR_LOCKUP_GUARD_EN reloads SEED from all-zero
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
        $error("lfsr_rng: WIDTH must be in 2..8");
    end
    if (SEED == '0 || TAPS == '0) begin : g_bad_cfg
        $error("lfsr_rng: SEED and TAPS must be non-zero");
    end

    always_comb begin
        state_d = WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS), WIDTH));
`ifdef LFSR_LOCKUP_GUARD_EN
        // All-zero is a fixed point of the XOR feedback; escape it by reseeding.
        if (state_q == '0) begin
            state_d = SEED;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign out = state_q;

`ifdef LFSR_LOCKUP_GUARD_EN
    a_never_zero: assert property (@(posedge clk) disable iff (!rst) out != '0)
        else $error("lfsr_rng: all-zero state observed");
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - randomized self-checking bench for lfsr_rng against a sequence model
module tb_lfsr_rng;

    logic clk;
    logic rst;
    logic check_en;
    logic model_valid;
    int   n_cmp;
    int   n_err;
    int   exp4;
    int   exp3;

    int seq4[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    int seq3[7]  = '{1, 2, 5, 3, 7, 6, 4};

    lfsr_rng_if #(.WIDTH(4)) if4 ();
    lfsr_rng_if #(.WIDTH(3)) if3 ();

    lfsr_rng dut4 (
        .clk (clk),
        .rst (rst),
        .out (if4.value)
    );

    lfsr_rng #(
        .WIDTH (3),
        .SEED  (3'b001),
        .TAPS  (3'b110)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .out (if3.value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift left, feed back the parity of the tapped bits, keep 'w' bits.
    function automatic int model_next(input int s, input int taps, input int w, input int seed);
        int fb;
`ifdef LFSR_LOCKUP_GUARD_EN
        if (s == 0) return seed;
`endif
        fb = $countones(s & taps) % 2;
        return ((s * 2) + fb) % (1 << w) + 0 * seed;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial model_valid = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            exp4        <= 1;
            exp3        <= 1;
            model_valid <= 1'b1;
        end else begin
            exp4 <= model_next(exp4, 'hC, 4, 1);
            exp3 <= model_next(exp3, 'h6, 3, 1);
        end
    end

    always @(negedge clk) begin
        if (model_valid && check_en) begin
            check("stream_w4", int'(if4.value), exp4);
            check("stream_w3", int'(if3.value), exp3);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hist[16];
        bit found;
        n_cmp    = 0;
        n_err    = 0;
        check_en = 1'b0;
        rst      = 1'b0;

        tick();
        check("reset_edge1_w4", int'(if4.value), 1);
        check("reset_edge1_w3", int'(if3.value), 1);
        tick();
        check("reset_held_w4", int'(if4.value), 1);
        check_en = 1'b1;

        rst = 1'b1;
        foreach (hist[i]) hist[i] = 0;
        for (int k = 0; k < 30; k++) begin
            hist[if4.value]++;
            check($sformatf("seq_w4_%0d", k), int'(if4.value), seq4[k % 15]);
            check($sformatf("seq_w3_%0d", k), int'(if3.value), seq3[k % 7]);
            tick();
        end
        check("never_zero", hist[0], 0);
        for (int v = 1; v < 16; v++) begin
            check($sformatf("coverage_%0h", v), hist[v], 2);
        end

        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (if4.value == 4'hA) found = 1'b1;
            else tick();
        end
        check("find_A", int'(found), 1);
        rst = 1'b0;
        tick();
        check("midrun_reset", int'(if4.value), 1);
        rst = 1'b1;
        tick();
        check("resume_2", int'(if4.value), 2);
        tick();
        check("resume_4", int'(if4.value), 4);

        for (int k = 0; k < 2000; k++) begin
            rst = ($urandom_range(0, 15) != 0);
            tick();
        end

        rst      = 1'b1;
        check_en = 1'b0;
        force dut4.state_q = '0;
        tick();
        check("forced_zero", int'(if4.value), 0);
        release dut4.state_q;
        tick();
`ifdef LFSR_LOCKUP_GUARD_EN
        check("lockup_reseed", int'(if4.value), 1);
`else
        check("lockup_persist", int'(if4.value), 0);
        tick();
        check("lockup_persist2", int'(if4.value), 0);
`endif

        rst = 1'b0;
        tick();
        check("recover_reset", int'(if4.value), 1);
        check_en = 1'b1;
        rst      = 1'b1;
        for (int k = 0; k < 40; k++) tick();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
